// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_e;

  localparam logic [3:0] COL_RESET  = 4'b1110;
  localparam logic [3:0] DISP_RESET = 4'hF;

  // Key code indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into the clock domain.
module keypad_row_sync (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_decoder.sv
// Column-scanning 4x4 keypad decoder with frame debounce and single-key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 8,
  parameter int unsigned REPEAT_SCANS   = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] DispVal,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]        row_s;
  logic [TICK_W-1:0] tick;
  logic [1:0]        col_idx;
  logic [1:0]        next_idx_c;
  logic [11:0]       frame;
  logic              sample_c;
  logic              frame_done_c;

  state_e            state;
  frame_class_e      prev_cls;
  logic [3:0]        prev_code;
  logic [CNT_W-1:0]  cnt;

  logic [3:0]        pressed_c;
  logic [15:0]       frame_full_c;
  logic [4:0]        n_set_c;
  logic [3:0]        bit_idx_c;
  frame_class_e      cls_c;
  logic [3:0]        code_c;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              deb_done_c;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  logic [REP_W-1:0] rep_cnt;
`else
  // Referenced only so the parameter stays part of the interface.
  localparam int unsigned unused_repeat_scans = REPEAT_SCANS;
`endif

  keypad_row_sync u_row_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (row),
    .q       (row_s)
  );

  assign sample_c     = (tick == TICK_W'(SCAN_TICKS - 1));
  assign frame_done_c = sample_c && (col_idx == 2'd3);
  assign next_idx_c   = col_idx + 2'd1;
  assign pressed_c    = ~row_s;

  // Column scan and snapshot of columns 0..2; column 3 is consumed live at frame end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick    <= '0;
      col_idx <= 2'd0;
      col     <= COL_RESET;
      frame   <= '0;
    end else if (sample_c) begin
      tick    <= '0;
      col_idx <= next_idx_c;
      col     <= ~(4'b0001 << next_idx_c);
      case (col_idx)
        2'd0:    frame[3:0]  <= pressed_c;
        2'd1:    frame[7:4]  <= pressed_c;
        2'd2:    frame[11:8] <= pressed_c;
        default: ;
      endcase
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  // Frame classification and debounce count for the frame completing this cycle.
  always_comb begin
    frame_full_c = {pressed_c, frame};
    n_set_c      = '0;
    bit_idx_c    = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_full_c[i]) begin
        n_set_c   = n_set_c + 5'd1;
        bit_idx_c = 4'(i);
      end
    end

    cls_c  = EMPTY;
    code_c = '0;
    if (n_set_c == 5'd1) begin
      cls_c  = SINGLE;
      code_c = KEY_MAP[{bit_idx_c[1:0], bit_idx_c[3:2]}];
    end else if (n_set_c != 5'd0) begin
      cls_c = MULTI;
    end

    if (cls_c == prev_cls && code_c == prev_code) begin
      cnt_nxt_c = (cnt >= CNT_W'(DEBOUNCE_SCANS)) ? CNT_W'(DEBOUNCE_SCANS) : cnt + CNT_W'(1);
    end else begin
      cnt_nxt_c = CNT_W'(1);
    end
    deb_done_c = (cnt_nxt_c == CNT_W'(DEBOUNCE_SCANS));
  end

  // Press/release FSM, advanced once per completed frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      DispVal   <= DISP_RESET;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      prev_cls  <= EMPTY;
      prev_code <= '0;
      cnt       <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done_c) begin
        prev_cls  <= cls_c;
        prev_code <= code_c;
        cnt       <= cnt_nxt_c;
        case (state)
          IDLE: begin
            if (cls_c == SINGLE && deb_done_c) begin
              DispVal   <= code_c;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt   <= '0;
`endif
            end
          end
          PRESSED: begin
            if (cls_c != SINGLE || code_c != DispVal) begin
              state <= RELEASE;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (rep_cnt == REP_W'(REPEAT_SCANS - 1)) begin
              rep_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
`endif
          end
          RELEASE: begin
            if (cls_c == EMPTY && deb_done_c) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end else if (cls_c == SINGLE && code_c == DispVal && deb_done_c) begin
              // Contact bounce on the held key: resume without a new strobe.
              state <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with a behavioural 4x4 keypad matrix model.
module tb_keypad_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] DispVal;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;   // bit 4*c+r set = key at (row r, col c) held down
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v0;
  int lat;
  bit ok;

  keypad_decoder #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .DispVal   (DispVal),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  // Matrix: a row reads low when a held key sits on a driven (low) column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[4*c+r]) row[r] = 1'b0;
  end

  always @(posedge clock)
    if (key_valid === 1'b1) vcount <= vcount + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int l, output bit found);
    found = 1'b0;
    l = 0;
    while (!found && l < max) begin
      @(posedge clock); #1;
      l++;
      if (key_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_held_low(input int max, output int l, output bit found);
    found = 1'b0;
    l = 0;
    while (!found && l < max) begin
      @(posedge clock); #1;
      l++;
      if (key_held === 1'b0) found = 1'b1;
    end
  endtask

  initial begin
    // Reset values and column rotation
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_col", 32'(col), 32'hE);
    check("rst_disp", 32'(DispVal), 32'hF);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("col0_hold", 32'(col), 32'hE);
    @(posedge clock); #1 check("col1", 32'(col), 32'hD);
    repeat (4) @(posedge clock);
    #1 check("col2", 32'(col), 32'hB);
    repeat (4) @(posedge clock);
    #1 check("col3", 32'(col), 32'h7);
    repeat (4) @(posedge clock);
    #1 check("col_wrap", 32'(col), 32'hE);

    // Single press of "5" (row 1, col 1)
    v0 = vcount;
    keys = 16'h0020;
    wait_valid(100, lat, ok);
    check("p5_seen", 32'(ok), 32'h1);
    check("p5_latency", 32'(lat), 32'd48);
    check("p5_disp", 32'(DispVal), 32'h5);
    check("p5_held", 32'(key_held), 32'h1);
    @(posedge clock); #1 check("p5_pulse_width", 32'(key_valid), 32'h0);
    repeat (80) @(posedge clock);
    #1;
`ifdef KEYPAD_AUTOREPEAT_EN
    check("p5_repeat_count", 32'(vcount - v0), 32'd3);
`else
    check("p5_once", 32'(vcount - v0), 32'd1);
`endif

    // Release: key_held drops after three empty frames, then re-press strobes again
    keys = '0;
    repeat (20) @(posedge clock);
    #1 check("rel_held_early", 32'(key_held), 32'h1);
    wait_held_low(100, lat, ok);
    check("rel_fall", 32'(ok), 32'h1);
    check("rel_latency", 32'(lat + 20), 32'd47);
    check("rel_disp_kept", 32'(DispVal), 32'h5);
    v0 = vcount;
    keys = 16'h0020;
    wait_valid(100, lat, ok);
    check("repress_seen", 32'(ok), 32'h1);
    check("repress_disp", 32'(DispVal), 32'h5);
    keys = '0;
    wait_held_low(100, lat, ok);
    check("repress_rel", 32'(ok), 32'h1);

    // Bounce on "9" (row 2, col 2): toggle every frame, then hold
    v0 = vcount;
    for (int i = 0; i < 4; i++) begin
      keys[10] = ~keys[10];
      repeat (16) @(posedge clock);
    end
    #1 check("bounce_quiet", 32'(vcount - v0), 32'd0);
    keys = 16'h0400;
    wait_valid(100, lat, ok);
    check("bounce_seen", 32'(ok), 32'h1);
    check("bounce_disp", 32'(DispVal), 32'h9);
    keys = '0;
    wait_held_low(100, lat, ok);
    check("bounce_rel", 32'(ok), 32'h1);

    // "1" (r0,c0) and "D" (r3,c3) together, then release "D"
    v0 = vcount;
    keys = 16'h8001;
    repeat (96) @(posedge clock);
    #1;
    check("multi_quiet", 32'(vcount - v0), 32'd0);
    check("multi_disp", 32'(DispVal), 32'h9);
    check("multi_held", 32'(key_held), 32'h0);
    keys = 16'h0001;
    wait_valid(100, lat, ok);
    check("multi_to_1", 32'(ok), 32'h1);
    check("multi_disp1", 32'(DispVal), 32'h1);
    keys = '0;
    wait_held_low(100, lat, ok);
    check("multi_rel", 32'(ok), 32'h1);

    // Held "5" plus "6" (r1,c2): the second key is never reported
    v0 = vcount;
    keys = 16'h0020;
    wait_valid(100, lat, ok);
    check("hold2_first", 32'(ok), 32'h1);
    keys = 16'h0220;
    repeat (64) @(posedge clock);
    #1 check("hold2_held", 32'(key_held), 32'h1);
    keys = 16'h0020;
    repeat (64) @(posedge clock);
    #1 check("hold2_disp", 32'(DispVal), 32'h5);
    keys = '0;
    wait_held_low(100, lat, ok);
    check("hold2_rel", 32'(ok), 32'h1);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("hold2_count", 32'(vcount - v0), 32'd1);
`endif

    // Reset while "0" (r3,c0) is held
    keys = 16'h0008;
    wait_valid(100, lat, ok);
    check("mid_first", 32'(ok), 32'h1);
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_disp", 32'(DispVal), 32'hF);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_held", 32'(key_held), 32'h0);
    @(negedge clock) reset_n = 1'b1;
    v0 = vcount;
    wait_valid(100, lat, ok);
    check("mid_again", 32'(ok), 32'h1);
    check("mid_disp", 32'(DispVal), 32'h0);
    check("mid_held", 32'(key_held), 32'h1);
`ifdef KEYPAD_AUTOREPEAT_EN
    wait_valid(40, lat, ok);
    check("rep1_latency", 32'(lat), 32'd32);
    wait_valid(40, lat, ok);
    check("rep2_latency", 32'(lat), 32'd32);
    check("rep_disp", 32'(DispVal), 32'h0);
`else
    repeat (96) @(posedge clock);
    #1 check("mid_once", 32'(vcount - v0), 32'd1);
`endif
    keys = '0;
    wait_held_low(100, lat, ok);
    check("mid_rel", 32'(ok), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Scans a 4x4 matrix keypad (Pmod KYPD style) by driving one column low at a time and sampling the four rows. It debounces the samples and decodes a single stable key press into a 4-bit code on `DispVal`, with a one-cycle `key_valid` strobe. It is the producer end of the `DispVal` interface that the seven-segment display controller consumes, and it sits between the keypad pins and the display/game logic.

## Interface
- `SCAN_TICKS`, 100000 — clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, 8 — consecutive identical frames required to accept a press or a release; must be ≥ 1.
- `REPEAT_SCANS`, 250 — frames between auto-repeat strobes; only used with `KEYPAD_AUTOREPEAT_EN`.
- `clock`  in  1  — system clock; all logic is on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `row`  in  4  — keypad rows, active-low (pulled up); asynchronous to `clock`.
- `col`  out  4  — keypad columns, active-low; exactly one bit is low at any time.
- `DispVal`  out  4  — code of the last accepted key; holds its value until the next accept.
- `key_valid`  out  1  — one-cycle pulse when `DispVal` is updated.
- `key_held`  out  1  — high while the accepted key remains debounced-pressed.

## Operation
- **Reset values:** `col`=4'b1110 (column 0 driven), `DispVal`=4'hF, `key_valid`=0, `key_held`=0. All counters are 0 and the FSM is in IDLE.
- **Key map (row r, col c):**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Scanning:**
  - The tick counter runs from 0 to SCAN_TICKS-1 per column.
  - The column index wraps 3→0.
  - Column c is driven as `col` = ~(1<<c).
- **Sampling:** the synchronized rows are captured on tick SCAN_TICKS-1 of each column window into bits [4c+3:4c] of a 16-bit frame snapshot. A row bit that reads 0 means pressed.
- **Frame classification:** a frame completes after column 3 is sampled.
  - 0 bits set → EMPTY.
  - 1 bit set → SINGLE(code).
  - More than 1 bit set → MULTI.
- **Debounce counter:** increments (saturating at DEBOUNCE_SCANS) when a frame's classification and code equal the previous frame's. Any change resets it to 1.
- **FSM states:**
  - IDLE:
    - On SINGLE with count reaching DEBOUNCE_SCANS: latch code into `DispVal`, pulse `key_valid`, set `key_held`=1, go to PRESSED.
    - MULTI or EMPTY: stay in IDLE.
  - PRESSED:
    - While frames stay SINGLE with the same code: stay.
    - Any other classification: go to RELEASE; `key_held` stays 1.
  - RELEASE:
    - EMPTY with count reaching DEBOUNCE_SCANS: `key_held`=0, go to IDLE.
    - SINGLE with the latched code reaching DEBOUNCE_SCANS again: return to PRESSED with no new strobe (bounce).
- **No auto-repeat by default:** a key is reported at most once per press/release cycle.
- **Held key plus second key:** the second key is never reported until both keys are released and a fresh single press is debounced.

## Timing
- `row` → 2-flop synchronizer → sample, so the sampled value reflects the pins ≥2 cycles earlier. SCAN_TICKS ≥ 4 guarantees the sample is taken after the column switch has settled.
- One frame = 4·SCAN_TICKS cycles.
- `key_valid` is asserted in the cycle immediately after the column-3 sample of the accepting frame. `DispVal` changes in that same cycle.
- **Minimum press latency:** DEBOUNCE_SCANS frames from the first frame that fully sees the key.
- **Reset mid-press:** everything reinitializes. If the key is still down, it is re-debounced from IDLE and reported exactly once.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter counts frames.
  - Every REPEAT_SCANS frames it pulses `key_valid` again, with `DispVal` unchanged.
  - The counter clears on entering PRESSED.
- `KEYPAD_AUTOREPEAT_EN` undefined: no repeat logic, and `REPEAT_SCANS` is ignored.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum (IDLE, PRESSED, RELEASE).
  - Frame class enum (EMPTY, SINGLE, MULTI).
  - 16-entry key map constant indexed by {r,c}.
  - Reset constants for `col` (4'b1110) and `DispVal` (4'hF).
- **Sub-module `keypad_row_sync`:** 4-bit, 2-flop synchronizer with async active-low reset to 4'b1111.

## Test plan
All scenarios use SCAN_TICKS=4 and DEBOUNCE_SCANS=3.
- **Reset:** after reset, `col`=1110, `DispVal`=F, `key_valid`=0; `col` rotates 1110→1101→1011→0111 every 4 cycles.
- **Single press:** hold key "5" (row1 low while col1 driven) → exactly one `key_valid` pulse, `DispVal`=4'h5, `key_held`=1 three frames (48 cycles) after first full frame.
- **Bounce:** toggle the "9" contact every frame for 4 frames, then hold steady → no strobe during toggling; single strobe with `DispVal`=4'h9 after 3 steady frames.
- **Multi-key:** press "1" and "D" together → no `key_valid`, `DispVal` unchanged; release "D" only → `DispVal`=4'h1 after 3 frames.
- **Release:** release a held key → `key_held` falls after 3 empty frames; re-press of the same key gives a second strobe.
- **Reset mid-press / auto-repeat:** assert `reset_n` while "0" is held → outputs return to reset values, then one strobe with `DispVal`=4'h0. With `KEYPAD_AUTOREPEAT_EN` and REPEAT_SCANS=2, strobes recur every 2 frames while the key is held.
